// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: a register-programmed bus slave that replays up to
// PAT_DEPTH 16-bit patterns into one LED controller register at a fixed cadence.
module led_pattern_seq #(
    parameter int unsigned PAT_DEPTH    = 8,
    parameter logic [31:0] LED_VAL_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        led_req_o,
    output logic        led_we_o,
    output logic [31:0] led_addr_o,
    output logic [31:0] led_wdata_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WAIT, ST_DONE} state_t;

    state_t      state;
    logic        ctrl_en;
    logic        ctrl_loop;
    logic        done;
    logic [31:0] period;
    logic [31:0] counter;
    logic [3:0]  len;
    logic [2:0]  idx;
    logic [15:0] pat [PAT_DEPTH];

    logic        wr;
    logic        rd;
    logic        busy;
    logic        sel_ctrl;
    logic        sel_period;
    logic        sel_len;
    logic        sel_status;
    logic        sel_pat;
    logic [2:0]  pat_sel;
    logic        ok_ctrl;
    logic        ok_period;
    logic        ok_len;
    logic        ok_pat;
    logic        stop;
    logic        wait_done;
    logic        last;
    logic [2:0]  next_idx;
    logic [15:0] pat_next;
    logic [15:0] pat_rd;
    logic [31:0] rd_val;

    always_comb begin
        wr         = req_i && write_enable_i;
        rd         = req_i && !write_enable_i;
        sel_ctrl   = (addr_i == 32'h00);
        sel_period = (addr_i == 32'h04);
        sel_len    = (addr_i == 32'h08);
        sel_status = (addr_i == 32'h0C);
        sel_pat    = (addr_i[1:0] == 2'b00) && (addr_i >= 32'h20) &&
                     (addr_i < (32'h20 + 4 * PAT_DEPTH));
        pat_sel    = addr_i[4:2];
        ok_ctrl    = (write_data_i <= 32'd3);
        ok_period  = (write_data_i != '0);
        ok_len     = (write_data_i != '0) && (write_data_i <= PAT_DEPTH);
        ok_pat     = (write_data_i <= 32'h0000_FFFF);

        busy      = (state == ST_WRITE) || (state == ST_WAIT);
        // Clearing EN wins over any pending transition, so an imminent write is dropped.
        stop      = wr && sel_ctrl && ok_ctrl && !write_data_i[0];
        wait_done = (counter >= (period - 32'd1));
        last      = ({1'b0, idx} >= (len - 4'd1));
        next_idx  = ((state == ST_WAIT) && !last) ? idx + 3'd1 : '0;

        pat_next = '0;
        pat_rd   = '0;
        for (int unsigned k = 0; k < PAT_DEPTH; k++) begin
            if (next_idx == 3'(k)) pat_next = pat[k];
            if (pat_sel == 3'(k))  pat_rd   = pat[k];
        end

        if (sel_ctrl)        rd_val = {30'b0, ctrl_loop, ctrl_en};
        else if (sel_period) rd_val = period;
        else if (sel_len)    rd_val = {28'b0, len};
        else if (sel_status) rd_val = {25'b0, idx, 2'b00, done, busy};
        else if (sel_pat)    rd_val = {16'h0, pat_rd};
        else                 rd_val = 32'hDEAD_BEEF;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            ctrl_en     <= 1'b0;
            ctrl_loop   <= 1'b0;
            done        <= 1'b0;
            period      <= 32'd1;
            len         <= 4'd1;
            idx         <= '0;
            counter     <= '0;
            for (int unsigned k = 0; k < PAT_DEPTH; k++) pat[k] <= '0;
            read_data_o <= '0;
            led_req_o   <= 1'b0;
            led_we_o    <= 1'b0;
            led_addr_o  <= '0;
            led_wdata_o <= '0;
        end else begin
            led_req_o   <= 1'b0;
            led_we_o    <= 1'b0;
            led_addr_o  <= '0;
            led_wdata_o <= '0;

            if (stop) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ctrl_en) begin
                            state       <= ST_WRITE;
                            idx         <= '0;
                            led_req_o   <= 1'b1;
                            led_we_o    <= 1'b1;
                            led_addr_o  <= LED_VAL_ADDR;
                            led_wdata_o <= {16'h0, pat_next};
                        end
                    end
                    ST_WRITE: begin
                        state   <= ST_WAIT;
                        counter <= '0;
                    end
                    ST_WAIT: begin
                        if (counter != '1) counter <= counter + 32'd1;
                        if (wait_done) begin
                            if (!last || ctrl_loop) begin
                                state       <= ST_WRITE;
                                idx         <= next_idx;
                                led_req_o   <= 1'b1;
                                led_we_o    <= 1'b1;
                                led_addr_o  <= LED_VAL_ADDR;
                                led_wdata_o <= {16'h0, pat_next};
                            end else begin
                                state   <= ST_DONE;
                                done    <= 1'b1;
                                ctrl_en <= 1'b0;
                            end
                        end
                    end
                    ST_DONE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end

            // Register writes come last so a same-edge CTRL write overrides the FSM's EN/DONE update.
            if (wr) begin
                if (sel_ctrl && ok_ctrl) begin
                    ctrl_en   <= write_data_i[0];
                    ctrl_loop <= write_data_i[1];
                    done      <= 1'b0;
                end
                if (sel_period && ok_period) period <= write_data_i;
                if (sel_len && ok_len)       len    <= write_data_i[3:0];
                if (sel_pat && ok_pat) begin
                    for (int unsigned k = 0; k < PAT_DEPTH; k++) begin
                        if (pat_sel == 3'(k)) pat[k] <= write_data_i[15:0];
                    end
                end
            end

            if (rd) read_data_o <= rd_val;
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: register map, one-shot, loop, abort,
// invalid writes and mid-sequence reset.
module tb_led_pattern_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        write_enable_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] write_data_i = '0;
    logic [31:0] read_data_o;
    logic        led_req_o;
    logic        led_we_o;
    logic [31:0] led_addr_o;
    logic [31:0] led_wdata_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_cyc = 0;
    int junk = 0;
    int bad_attr = 0;
    int          pulse_cyc[$];
    logic [31:0] pulse_data[$];

    led_pattern_seq #(.PAT_DEPTH(8), .LED_VAL_ADDR(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_enable_i(write_enable_i),
        .addr_i(addr_i), .write_data_i(write_data_i), .read_data_o(read_data_o),
        .led_req_o(led_req_o), .led_we_o(led_we_o), .led_addr_o(led_addr_o),
        .led_wdata_o(led_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (led_req_o) begin
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(led_wdata_o);
            if (led_we_o !== 1'b1 || led_addr_o !== 32'h0) bad_attr <= bad_attr + 1;
        end else if (led_we_o !== 1'b0 || led_addr_o !== 32'h0 || led_wdata_o !== 32'h0) begin
            junk <= junk + 1;
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
        @(negedge clk_i);
        wr_cyc = cyc;
        req_i = 1'b0; write_enable_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
        @(negedge clk_i);
        d = read_data_o;
        req_i = 1'b0;
    endtask

    task automatic clear_pulses();
        pulse_cyc.delete();
        pulse_data.delete();
    endtask

    task automatic program_two();
        wr(32'h20, 32'h0000_00FF);
        wr(32'h24, 32'h0000_FF00);
        wr(32'h08, 32'd2);
        wr(32'h04, 32'd3);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({led_req_o, led_we_o, led_addr_o, led_wdata_o} !== '0) begin
            n_bad++; $display("FAIL reset_led: got req=%b we=%b addr=%h data=%h required all 0", led_req_o, led_we_o, led_addr_o, led_wdata_o);
        end
        n_cmp++;
        if (read_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h required 0", read_data_o); end
        rst_i = 1'b0;
        @(negedge clk_i);
        rd(32'h04, v); n_cmp++;
        if (v !== 32'd1) begin n_bad++; $display("FAIL reset_period: got %h required 1", v); end
        rd(32'h08, v); n_cmp++;
        if (v !== 32'd1) begin n_bad++; $display("FAIL reset_len: got %h required 1", v); end
        rd(32'h00, v); n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL reset_ctrl: got %h required 0", v); end
        rd(32'h0C, v); n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL reset_status: got %h required 0", v); end
        rd(32'h20, v); n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL reset_pat0: got %h required 0", v); end
        rd(32'h40, v); n_cmp++;
        if (v !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL unmapped_read: got %h required deadbeef", v); end
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (read_data_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rdata_hold: got %h required deadbeef", read_data_o); end
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        program_two();
        clear_pulses();
        wr(32'h00, 32'd1);
        repeat (25) @(negedge clk_i);
        n_cmp++;
        if (pulse_cyc.size() != 2) begin
            n_bad++; $display("FAIL oneshot_count: got %0d pulses required 2", pulse_cyc.size());
        end else begin
            n_cmp++;
            if (pulse_cyc[0] != wr_cyc + 1) begin n_bad++; $display("FAIL oneshot_latency: got %0d cycles required 1", pulse_cyc[0] - wr_cyc); end
            n_cmp++;
            if (pulse_data[0] !== 32'h0000_00FF) begin n_bad++; $display("FAIL oneshot_data0: got %h required 000000ff", pulse_data[0]); end
            n_cmp++;
            if (pulse_data[1] !== 32'h0000_FF00) begin n_bad++; $display("FAIL oneshot_data1: got %h required 0000ff00", pulse_data[1]); end
            n_cmp++;
            if (pulse_cyc[1] - pulse_cyc[0] != 4) begin n_bad++; $display("FAIL oneshot_gap: got %0d required 4", pulse_cyc[1] - pulse_cyc[0]); end
        end
        rd(32'h0C, v); n_cmp++;
        if (v[1:0] !== 2'b10) begin n_bad++; $display("FAIL oneshot_status: got done,busy=%b required 10", v[1:0]); end
        rd(32'h00, v); n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL oneshot_ctrl: got %h required 0", v); end
    endtask

    task automatic test_loop();
        logic [31:0] v;
        logic [31:0] exp_d;
        clear_pulses();
        wr(32'h00, 32'd3);
        repeat (18) @(negedge clk_i);
        rd(32'h0C, v); n_cmp++;
        if (v[1:0] !== 2'b01) begin n_bad++; $display("FAIL loop_status: got done,busy=%b required 01", v[1:0]); end
        wr(32'h00, 32'd0);
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (pulse_cyc.size() < 5) begin
            n_bad++; $display("FAIL loop_count: got %0d pulses required at least 5", pulse_cyc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                exp_d = (i % 2 == 0) ? 32'h0000_00FF : 32'h0000_FF00;
                n_cmp++;
                if (pulse_data[i] !== exp_d) begin n_bad++; $display("FAIL loop_data%0d: got %h required %h", i, pulse_data[i], exp_d); end
                if (i > 0) begin
                    n_cmp++;
                    if (pulse_cyc[i] - pulse_cyc[i-1] != 4) begin n_bad++; $display("FAIL loop_gap%0d: got %0d required 4", i, pulse_cyc[i] - pulse_cyc[i-1]); end
                end
            end
        end
        rd(32'h0C, v); n_cmp++;
        if (v[1:0] !== 2'b00) begin n_bad++; $display("FAIL loop_stop_status: got done,busy=%b required 00", v[1:0]); end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        clear_pulses();
        wr(32'h00, 32'd1);
        repeat (4) @(negedge clk_i);
        wr(32'h00, 32'd0);
        repeat (20) @(negedge clk_i);
        n_cmp++;
        if (pulse_cyc.size() != 1) begin n_bad++; $display("FAIL abort_count: got %0d pulses required 1", pulse_cyc.size()); end
        rd(32'h0C, v); n_cmp++;
        if (v[1:0] !== 2'b00) begin n_bad++; $display("FAIL abort_status: got done,busy=%b required 00", v[1:0]); end
    endtask

    task automatic test_invalid();
        logic [31:0] v;
        clear_pulses();
        wr(32'h04, 32'd0);
        wr(32'h08, 32'd9);
        wr(32'h08, 32'd0);
        wr(32'h20, 32'h0001_0000);
        wr(32'h00, 32'd4);
        wr(32'h0C, 32'hFF);
        wr(32'h40, 32'd1);
        wr(32'h22, 32'h1234);
        rd(32'h04, v); n_cmp++;
        if (v !== 32'd3) begin n_bad++; $display("FAIL inv_period: got %h required 3", v); end
        rd(32'h08, v); n_cmp++;
        if (v !== 32'd2) begin n_bad++; $display("FAIL inv_len: got %h required 2", v); end
        rd(32'h20, v); n_cmp++;
        if (v !== 32'h00FF) begin n_bad++; $display("FAIL inv_pat0: got %h required 00ff", v); end
        rd(32'h00, v); n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL inv_ctrl: got %h required 0", v); end
        wr(32'h08, 32'd8);
        rd(32'h08, v); n_cmp++;
        if (v !== 32'd8) begin n_bad++; $display("FAIL len_max: got %h required 8", v); end
        wr(32'h3C, 32'hFFFF);
        rd(32'h3C, v); n_cmp++;
        if (v !== 32'hFFFF) begin n_bad++; $display("FAIL pat7_max: got %h required ffff", v); end
        repeat (5) @(negedge clk_i);
        n_cmp++;
        if (pulse_cyc.size() != 0) begin n_bad++; $display("FAIL inv_no_pulse: got %0d pulses required 0", pulse_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(32'h08, 32'd2);
        clear_pulses();
        wr(32'h00, 32'd3);
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if (pulse_cyc.size() != 1) begin n_bad++; $display("FAIL rstmid_started: got %0d pulses required 1", pulse_cyc.size()); end
        #2 rst_i = 1'b1;
        #1;
        n_cmp++;
        if ({led_req_o, led_we_o, led_addr_o, led_wdata_o} !== '0) begin
            n_bad++; $display("FAIL rstmid_led: got req=%b data=%h required 0", led_req_o, led_wdata_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        clear_pulses();
        repeat (30) @(negedge clk_i);
        n_cmp++;
        if (pulse_cyc.size() != 0) begin n_bad++; $display("FAIL rstmid_no_pulse: got %0d pulses required 0", pulse_cyc.size()); end
        rd(32'h00, v); n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL rstmid_ctrl: got %h required 0", v); end
        rd(32'h20, v); n_cmp++;
        if (v !== 32'd0) begin n_bad++; $display("FAIL rstmid_pat0: got %h required 0", v); end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_oneshot();
        test_loop();
        test_abort();
        test_invalid();
        test_reset_mid();
        n_cmp++;
        if (bad_attr != 0) begin n_bad++; $display("FAIL led_attr: got %0d bad write pulses required 0", bad_attr); end
        n_cmp++;
        if (junk != 0) begin n_bad++; $display("FAIL led_idle: got %0d nonzero idle cycles required 0", junk); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
